// File: rtl/tx_frame_buffer.sv
// tx_frame_buffer: ping-pong stereo frame buffer feeding i2s_tx.
// One bank is filled from the DSP stage while the other is played out,
// one stereo entry per LRCK frame. Banks exchange roles only when the play
// bank is exhausted and the fill bank is complete; otherwise silence is
// emitted and an underrun is flagged.
module tx_frame_buffer #(
    parameter int SAMPLE_SIZE = 24,
    parameter int WORD_SIZE   = 32,
    parameter int BUFF_SIZE   = 64,
    parameter int PTR_BITS    = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   lrck,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [SAMPLE_SIZE-1:0] wr_l,
    input  logic [SAMPLE_SIZE-1:0] wr_r,
    output logic [WORD_SIZE-1:0]   l_dout,
    output logic [WORD_SIZE-1:0]   r_dout,
    output logic                   play_bank,
    output logic                   swap,
    output logic                   underrun,
    output logic                   underrun_sticky
);

    localparam int ENTRY_W = 2 * SAMPLE_SIZE;
    localparam int PAD_W   = WORD_SIZE - SAMPLE_SIZE;

    typedef enum logic {
        WR_FILL,
        WR_FULL
    } wr_state_t;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_PLAY,
        RD_STARVED
    } rd_state_t;

    // Both banks live in one array; the MSB of the address selects the bank.
    logic [ENTRY_W-1:0] mem [0:2*BUFF_SIZE-1];
    logic [ENTRY_W-1:0] rd_data_q;

    logic               prev_lrck_q, prev_lrck_d;
    wr_state_t          wr_state_q, wr_state_d;
    logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    rd_state_t          rd_state_q, rd_state_d;
    logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic               play_bank_q, play_bank_d;
    logic               swap_q, swap_d;
    logic               underrun_q, underrun_d;
    logic               sticky_q, sticky_d;
    // Stage 0: read request issued on the strobe edge.
    logic               rd_en_q, rd_en_d;
    logic               mute_q, mute_d;
    logic [PTR_BITS:0]  rd_addr_q, rd_addr_d;
    // Stage 1: RAM data valid, decide whether the output register loads.
    logic               load_q, load_d;
    logic               sel_q, sel_d;
    // Stage 2: output words.
    logic [WORD_SIZE-1:0] l_dout_q, l_dout_d;
    logic [WORD_SIZE-1:0] r_dout_q, r_dout_d;

    logic strobe;
    logic wr_fire;
    logic fill_full;
    logic do_swap;

    // Left-channel start: LRCK seen falling.
    assign strobe    = prev_lrck_q & ~lrck;
    assign fill_full = (wr_state_q == WR_FULL);
    // Held low during the swap cycle so no write lands while roles change.
    assign wr_ready  = (wr_state_q == WR_FILL) & ~swap_q;
    assign wr_fire   = wr_valid & wr_ready;

    // Next-state logic for the write side, read side and output pipeline.
    always_comb begin
        prev_lrck_d = lrck;
        wr_state_d  = wr_state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_state_d  = rd_state_q;
        rd_ptr_d    = rd_ptr_q;
        play_bank_d = play_bank_q;
        swap_d      = 1'b0;
        underrun_d  = 1'b0;
        rd_en_d     = 1'b0;
        mute_d      = 1'b0;
        rd_addr_d   = rd_addr_q;
        do_swap     = 1'b0;

        if (wr_fire) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (wr_ptr_q == PTR_BITS'(BUFF_SIZE - 1)) begin
                wr_state_d = WR_FULL;
            end
        end

        if (strobe) begin
            case (rd_state_q)
                RD_IDLE: begin
                    if (fill_full) begin
                        do_swap = 1'b1;
                    end
                end
                RD_PLAY: begin
                    // rd_ptr only reads zero in PLAY once entry BUFF_SIZE-1 has gone out.
                    if (rd_ptr_q != '0) begin
                        rd_en_d   = 1'b1;
                        rd_addr_d = {play_bank_q, rd_ptr_q};
                        rd_ptr_d  = rd_ptr_q + 1'b1;
                    end else if (fill_full) begin
                        do_swap = 1'b1;
                    end else begin
                        rd_state_d = RD_STARVED;
                        underrun_d = 1'b1;
                        mute_d     = 1'b1;
                    end
                end
                RD_STARVED: begin
                    if (fill_full) begin
                        do_swap = 1'b1;
                    end else begin
                        underrun_d = 1'b1;
                        mute_d     = 1'b1;
                    end
                end
                default: begin
                    rd_state_d = RD_IDLE;
                end
            endcase
        end

        // Swap: the freshly filled bank plays from entry 0 on this same strobe.
        if (do_swap) begin
            swap_d      = 1'b1;
            play_bank_d = ~play_bank_q;
            rd_state_d  = RD_PLAY;
            rd_en_d     = 1'b1;
            rd_addr_d   = {~play_bank_q, {PTR_BITS{1'b0}}};
            rd_ptr_d    = PTR_BITS'(1);
            wr_state_d  = WR_FILL;
            wr_ptr_d    = '0;
        end

        sticky_d = sticky_q | underrun_d;

        load_d   = rd_en_q | mute_q;
        sel_d    = rd_en_q;
        l_dout_d = l_dout_q;
        r_dout_d = r_dout_q;
        if (load_q) begin
            if (sel_q) begin
                l_dout_d = {rd_data_q[ENTRY_W-1:SAMPLE_SIZE], {PAD_W{1'b0}}};
                r_dout_d = {rd_data_q[SAMPLE_SIZE-1:0], {PAD_W{1'b0}}};
            end else begin
                l_dout_d = '0;
                r_dout_d = '0;
            end
        end
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_lrck_q <= 1'b0;
            wr_state_q  <= WR_FILL;
            wr_ptr_q    <= '0;
            rd_state_q  <= RD_IDLE;
            rd_ptr_q    <= '0;
            play_bank_q <= 1'b1;
            swap_q      <= 1'b0;
            underrun_q  <= 1'b0;
            sticky_q    <= 1'b0;
            rd_en_q     <= 1'b0;
            mute_q      <= 1'b0;
            rd_addr_q   <= '0;
            load_q      <= 1'b0;
            sel_q       <= 1'b0;
            l_dout_q    <= '0;
            r_dout_q    <= '0;
        end else begin
            prev_lrck_q <= prev_lrck_d;
            wr_state_q  <= wr_state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_state_q  <= rd_state_d;
            rd_ptr_q    <= rd_ptr_d;
            play_bank_q <= play_bank_d;
            swap_q      <= swap_d;
            underrun_q  <= underrun_d;
            sticky_q    <= sticky_d;
            rd_en_q     <= rd_en_d;
            mute_q      <= mute_d;
            rd_addr_q   <= rd_addr_d;
            load_q      <= load_d;
            sel_q       <= sel_d;
            l_dout_q    <= l_dout_d;
            r_dout_q    <= r_dout_d;
        end
    end

    // RAM write port: accepted pairs go into the bank not being played.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[{~play_bank_q, wr_ptr_q}] <= {wr_l, wr_r};
        end
    end

    // RAM read port, registered one edge after the strobe.
    always_ff @(posedge clk) begin
        if (rd_en_q) begin
            rd_data_q <= mem[rd_addr_q];
        end
    end

    assign l_dout          = l_dout_q;
    assign r_dout          = r_dout_q;
    assign play_bank       = play_bank_q;
    assign swap            = swap_q;
    assign underrun        = underrun_q;
    assign underrun_sticky = sticky_q;

endmodule

// File: tb/tb_tx_frame_buffer.sv
// Bench for tx_frame_buffer: randomized writes against a frame-level model
// of the ping-pong buffer (bank arrays, fill count, entries-played count).
module tb_tx_frame_buffer;

    localparam int SS   = 24;
    localparam int WS   = 32;
    localparam int BS   = 64;
    localparam int PB   = 6;
    localparam int HALF = 8;
    localparam logic [WS-SS-1:0] PAD = '0;
    localparam int M_IDLE = 0, M_PLAY = 1, M_STARVED = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          lrck = 1'b0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [SS-1:0] wr_l = '0;
    logic [SS-1:0] wr_r = '0;
    logic [WS-1:0] l_dout, r_dout;
    logic          play_bank, swap, underrun, underrun_sticky;

    always #5 clk = ~clk;

    tx_frame_buffer #(
        .SAMPLE_SIZE(SS), .WORD_SIZE(WS), .BUFF_SIZE(BS), .PTR_BITS(PB)
    ) dut (
        .clk(clk), .rst(rst), .lrck(lrck),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_l(wr_l), .wr_r(wr_r),
        .l_dout(l_dout), .r_dout(r_dout),
        .play_bank(play_bank), .swap(swap),
        .underrun(underrun), .underrun_sticky(underrun_sticky)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int  ph = 0;
    bit  m_prev, m_full, m_swap_last, m_play, m_sticky;
    int  m_fill, m_mode, m_rd, m_swaps = 0, m_frames = 0;
    logic [2*SS-1:0] m_bank [2][BS];
    bit  e_swap, e_under;
    logic [WS-1:0] e_l, e_r;
    bit  ev1_v, ev2_v;
    logic [WS-1:0] ev1_l, ev1_r, ev2_l, ev2_r;

    function automatic logic lrck_val(input int p);
        return ((p % (2 * HALF)) >= HALF);
    endfunction

    function automatic bit m_ready();
        return (!m_full && !m_swap_last);
    endfunction

    function automatic bit next_strobe();
        return (lrck_val(ph) == 1'b0) && m_prev;
    endfunction

    // Model of one clk edge, from the inputs presented at that edge.
    task automatic model_edge();
        bit strobe, fire, swapped, ev_v;
        logic [2*SS-1:0] ent;
        int fb;
        if (rst) begin
            m_prev = 0; m_full = 0; m_fill = 0; m_swap_last = 0; m_play = 1;
            m_mode = M_IDLE; m_rd = 0; m_sticky = 0;
            e_swap = 0; e_under = 0; e_l = '0; e_r = '0; ev1_v = 0; ev2_v = 0;
            return;
        end
        fire    = wr_valid && m_ready();
        strobe  = m_prev && !lrck;
        swapped = 0; ev_v = 0; ent = '0; e_under = 0;
        if (strobe) begin
            m_frames++;
            if (m_mode == M_PLAY && m_rd < BS) begin
                ent = m_bank[int'(m_play)][m_rd];
                ev_v = 1;
                $display("frame %0d: play bank=%0d entry=%0d data=%h", m_frames, m_play, m_rd, ent);
                m_rd++;
            end else if (m_mode != M_IDLE || m_full) begin
                if (m_full) begin
                    m_play = !m_play; m_full = 0; m_fill = 0; m_mode = M_PLAY;
                    ent = m_bank[int'(m_play)][0]; ev_v = 1; m_rd = 1;
                    swapped = 1; m_swaps++;
                    $display("frame %0d: swap to bank=%0d entry=0 data=%h", m_frames, m_play, ent);
                end else begin
                    m_mode = M_STARVED; e_under = 1; m_sticky = 1; ev_v = 1;
                    $display("frame %0d: silence (underrun)", m_frames);
                end
            end else begin
                $display("frame %0d: idle", m_frames);
            end
        end
        if (fire) begin
            fb = m_play ? 0 : 1;
            m_bank[fb][m_fill] = {wr_l, wr_r};
            m_fill++;
            if (m_fill == BS) m_full = 1;
        end
        e_swap = swapped;
        m_swap_last = swapped;
        if (ev2_v) begin
            e_l = ev2_l; e_r = ev2_r;
        end
        ev2_v = ev1_v; ev2_l = ev1_l; ev2_r = ev1_r;
        ev1_v = ev_v; ev1_l = {ent[2*SS-1:SS], PAD}; ev1_r = {ent[SS-1:0], PAD};
        m_prev = lrck;
    endtask

    // Present inputs, advance one edge, update the model, settle 1 time unit.
    task automatic step(input bit v, input logic [SS-1:0] l, input logic [SS-1:0] r);
        wr_valid = v; wr_l = l; wr_r = r;
        lrck = lrck_val(ph);
        ph++;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step(0, '0, '0);
        rst = 1'b0;
        checks++;
        if ({l_dout, r_dout} !== 64'h0) begin
            errors++;
            $display("FAIL reset_dout l=%h r=%h expected 0", l_dout, r_dout);
        end
        checks++;
        if ({swap, underrun, underrun_sticky, wr_ready, play_bank} !== 5'b00011) begin
            errors++;
            $display("FAIL reset_flags got=%b expected=00011",
                     {swap, underrun, underrun_sticky, wr_ready, play_bank});
        end
        for (int i = 0; i < 3 * 2 * HALF; i++) begin
            step(0, SS'($urandom), SS'($urandom));
            checks++;
            if ({l_dout, r_dout, underrun, wr_ready, play_bank} !== {64'h0, 3'b011}) begin
                errors++;
                if (errors <= 40) $display("FAIL idle_state l=%h r=%h flags=%b expected 0 0 011",
                                           l_dout, r_dout, {underrun, wr_ready, play_bank});
            end
        end
    endtask

    task automatic test_fill_first_swap();
        int n = 0;
        bit acc, seen = 0;
        for (int k = 0; k < 200 && n < BS; k++) begin
            acc = m_ready();
            step(1, SS'(n), SS'(-n));
            if (acc) n++;
            checks++;
            if ({swap, underrun, underrun_sticky, wr_ready, play_bank} !==
                {e_swap, e_under, m_sticky, m_ready(), m_play}) begin
                errors++;
                if (errors <= 40) $display("FAIL fill_flags got=%b expected=%b",
                    {swap, underrun, underrun_sticky, wr_ready, play_bank},
                    {e_swap, e_under, m_sticky, m_ready(), m_play});
            end
        end
        checks++;
        if (wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_ready wr_ready=%b expected 0", wr_ready);
        end
        for (int k = 0; k < 40 && !seen; k++) begin
            step(1, SS'($urandom), SS'($urandom));
            if (e_swap) seen = 1;
            checks++;
            if ({swap, play_bank} !== {e_swap, m_play}) begin
                errors++;
                if (errors <= 40) $display("FAIL first_swap swap/bank=%b expected=%b",
                                           {swap, play_bank}, {e_swap, m_play});
            end
        end
        checks++;
        if (!seen || play_bank !== 1'b0) begin
            errors++;
            $display("FAIL first_swap_seen seen=%0d play_bank=%b expected 1 0", seen, play_bank);
        end
        step(0, '0, '0);
        step(0, '0, '0);
        checks++;
        if ({l_dout, r_dout} !== 64'h0) begin
            errors++;
            $display("FAIL entry0_out l=%h r=%h expected 0 0", l_dout, r_dout);
        end
        for (int k = 0; k < 2 * HALF; k++) begin
            step(0, '0, '0);
            checks++;
            if ({l_dout, r_dout} !== {e_l, e_r}) begin
                errors++;
                if (errors <= 40) $display("FAIL fill_data l=%h r=%h expected l=%h r=%h",
                                           l_dout, r_dout, e_l, e_r);
            end
        end
        checks++;
        if ({l_dout, r_dout} !== {32'h0000_0100, 32'hFFFF_FF00}) begin
            errors++;
            $display("FAIL entry1_out l=%h r=%h expected 00000100 ffffff00", l_dout, r_dout);
        end
    endtask

    task automatic test_streaming();
        int start = m_swaps;
        for (int k = 0; k < 1400 && m_swaps == start; k++) begin
            step($urandom_range(0, 3) != 0, SS'($urandom), SS'($urandom));
            checks++;
            if ({l_dout, r_dout} !== {e_l, e_r}) begin
                errors++;
                if (errors <= 40) $display("FAIL stream_data l=%h r=%h expected l=%h r=%h",
                                           l_dout, r_dout, e_l, e_r);
            end
            checks++;
            if ({swap, underrun, underrun_sticky, wr_ready, play_bank} !==
                {e_swap, 1'b0, 1'b0, m_ready(), m_play}) begin
                errors++;
                if (errors <= 40) $display("FAIL stream_flags got=%b expected=%b",
                    {swap, underrun, underrun_sticky, wr_ready, play_bank},
                    {e_swap, 1'b0, 1'b0, m_ready(), m_play});
            end
        end
        checks++;
        if (m_swaps == start || play_bank !== 1'b1) begin
            errors++;
            $display("FAIL stream_swap play_bank=%b expected 1 after bank end", play_bank);
        end
    endtask

    task automatic test_starvation();
        int n = 0, unders = 0, start;
        bit acc;
        for (int k = 0; k < 1500 && (n < 10 || unders < 3); k++) begin
            acc = m_ready();
            step(n < 10, SS'($urandom), SS'($urandom));
            if (acc && n < 10) n++;
            if (e_under) unders++;
            checks++;
            if ({l_dout, r_dout, swap, underrun, underrun_sticky, wr_ready, play_bank} !==
                {e_l, e_r, e_swap, e_under, m_sticky, m_ready(), m_play}) begin
                errors++;
                if (errors <= 40) $display("FAIL starve_state l=%h r=%h flags=%b expected l=%h r=%h flags=%b",
                    l_dout, r_dout, {swap, underrun, underrun_sticky, wr_ready, play_bank},
                    e_l, e_r, {e_swap, e_under, m_sticky, m_ready(), m_play});
            end
        end
        checks++;
        if (underrun_sticky !== 1'b1 || unders < 3) begin
            errors++;
            $display("FAIL starve_sticky sticky=%b pulses=%0d expected 1 >=3", underrun_sticky, unders);
        end
        start = m_swaps;
        for (int k = 0; k < 400 && m_swaps == start; k++) begin
            acc = m_ready();
            step(n < BS, SS'($urandom), SS'($urandom));
            if (acc && n < BS) n++;
            checks++;
            if ({l_dout, r_dout, swap, underrun, underrun_sticky, wr_ready, play_bank} !==
                {e_l, e_r, e_swap, e_under, m_sticky, m_ready(), m_play}) begin
                errors++;
                if (errors <= 40) $display("FAIL refill_state l=%h r=%h flags=%b expected l=%h r=%h flags=%b",
                    l_dout, r_dout, {swap, underrun, underrun_sticky, wr_ready, play_bank},
                    e_l, e_r, {e_swap, e_under, m_sticky, m_ready(), m_play});
            end
        end
        checks++;
        if (m_swaps == start || swap !== 1'b1) begin
            errors++;
            $display("FAIL refill_swap swap=%b expected 1", swap);
        end
    endtask

    task automatic test_simultaneous();
        int n = 0;
        bit acc, hit = 0;
        for (int k = 0; k < 400 && n < BS - 1; k++) begin
            acc = m_ready();
            step($urandom_range(0, 3) != 0 && n < BS - 1, SS'($urandom), SS'($urandom));
            if (acc && wr_valid) n++;
            checks++;
            if ({l_dout, r_dout} !== {e_l, e_r}) begin
                errors++;
                if (errors <= 40) $display("FAIL simul_data l=%h r=%h expected l=%h r=%h",
                                           l_dout, r_dout, e_l, e_r);
            end
        end
        for (int k = 0; k < 1400 && !hit; k++) begin
            if (m_mode == M_PLAY && m_rd == BS && next_strobe()) hit = 1;
            else begin
                step(0, '0, '0);
                checks++;
                if ({l_dout, r_dout, swap, underrun} !== {e_l, e_r, e_swap, e_under}) begin
                    errors++;
                    if (errors <= 40) $display("FAIL simul_play l=%h r=%h su=%b expected l=%h r=%h su=%b",
                        l_dout, r_dout, {swap, underrun}, e_l, e_r, {e_swap, e_under});
                end
            end
        end
        step(1, SS'($urandom), SS'($urandom));
        checks++;
        if (!hit || {swap, underrun, wr_ready} !== 3'b010) begin
            errors++;
            $display("FAIL simul_end hit=%0d swap/underrun/ready=%b expected 1 010",
                     hit, {swap, underrun, wr_ready});
        end
        for (int k = 0; k < 2 * HALF; k++) begin
            step(0, '0, '0);
            checks++;
            if ({l_dout, r_dout, swap, underrun} !== {e_l, e_r, e_swap, e_under}) begin
                errors++;
                if (errors <= 40) $display("FAIL simul_next l=%h r=%h su=%b expected l=%h r=%h su=%b",
                    l_dout, r_dout, {swap, underrun}, e_l, e_r, {e_swap, e_under});
            end
        end
        checks++;
        if (swap !== 1'b1) begin
            errors++;
            $display("FAIL simul_swap swap=%b expected 1 at following strobe", swap);
        end
    endtask

    task automatic test_reset_mid();
        bit hit = 0;
        for (int k = 0; k < 1000 && !hit; k++) begin
            step($urandom_range(0, 1) != 0, SS'($urandom), SS'($urandom));
            if (m_mode == M_PLAY && m_rd == 30) hit = 1;
            checks++;
            if ({l_dout, r_dout} !== {e_l, e_r}) begin
                errors++;
                if (errors <= 40) $display("FAIL mid_data l=%h r=%h expected l=%h r=%h",
                                           l_dout, r_dout, e_l, e_r);
            end
        end
        rst = 1'b1;
        step(1, SS'($urandom), SS'($urandom));
        rst = 1'b0;
        checks++;
        if (!hit || {l_dout, r_dout} !== 64'h0) begin
            errors++;
            $display("FAIL mid_reset_dout hit=%0d l=%h r=%h expected 1 0 0", hit, l_dout, r_dout);
        end
        checks++;
        if ({swap, underrun, underrun_sticky, wr_ready, play_bank} !== 5'b00011) begin
            errors++;
            $display("FAIL mid_reset_flags got=%b expected=00011",
                     {swap, underrun, underrun_sticky, wr_ready, play_bank});
        end
        for (int k = 0; k < 4 * HALF; k++) begin
            step(0, '0, '0);
            checks++;
            if ({l_dout, r_dout, swap, underrun, underrun_sticky, wr_ready, play_bank} !==
                {e_l, e_r, e_swap, e_under, m_sticky, m_ready(), m_play}) begin
                errors++;
                if (errors <= 40) $display("FAIL post_reset l=%h r=%h flags=%b expected l=%h r=%h flags=%b",
                    l_dout, r_dout, {swap, underrun, underrun_sticky, wr_ready, play_bank},
                    e_l, e_r, {e_swap, e_under, m_sticky, m_ready(), m_play});
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_first_swap();
        test_streaming();
        test_starvation();
        test_simultaneous();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tx_frame_buffer.md
# tx_frame_buffer

Ping-pong stereo frame buffer between the DSP processing stage and `i2s_tx`. The DSP side fills one bank through a valid/ready handshake while the other bank is played out one stereo sample per LRCK frame. Outputs are the left-justified 32-bit words that drive `i2s_tx` `l_din`/`r_din`. Banks swap only when the play bank is exhausted and the fill bank is full. Otherwise the block outputs silence and flags an underrun.

## Interface
- `SAMPLE_SIZE`, 24: signed sample width on the write side.
- `WORD_SIZE`, 32: output word width; word = {sample, (WORD_SIZE-SAMPLE_SIZE) zeros}.
- `BUFF_SIZE`, 64: stereo entries per bank.
- `PTR_BITS`, 6: log2(BUFF_SIZE).
- `clk` in 1: audio bit clock (same net as `i2s_tx` bck); all state changes on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `lrck` in 1: frame clock, sampled on `clk`.
- `wr_valid` in 1: write request from the DSP stage.
- `wr_ready` out 1: bank can accept a write.
- `wr_l`, `wr_r` in SAMPLE_SIZE: stereo sample pair to write.
- `l_dout`, `r_dout` out WORD_SIZE: words to `i2s_tx`.
- `play_bank` out 1: index of the bank currently playing.
- `swap` out 1: one-cycle pulse when the banks exchange roles.
- `underrun` out 1: one-cycle pulse on each frame output as silence after playback has started.
- `underrun_sticky` out 1: set by `underrun`, cleared only by `rst`.

## Operation
- Storage is two banks of BUFF_SIZE x (2*SAMPLE_SIZE), inferred RAM with synchronous read.
- **Frame strobe:** `prev_lrck` is registered every cycle. The strobe is `prev_lrck==1 && lrck==0`, i.e. the left-channel start.
- **Write side states:**
  - FILL: `wr_ready`=1. A write occurs when `wr_valid && wr_ready`. It stores {`wr_l`,`wr_r`} at `wr_ptr` in the fill bank (`!play_bank`), then `wr_ptr`++.
  - When the write at `wr_ptr`==BUFF_SIZE-1 completes, `wr_ptr` wraps to 0 and the state goes to FULL.
  - FULL: `wr_ready`=0. A write attempted while not ready is ignored.
  - On `swap`, the state returns to FILL with `wr_ptr`=0.
- **Read side states:**
  - IDLE after reset: outputs 0, no underrun pulses. On a strobe with the write side FULL, go to PLAY via swap.
  - PLAY: each strobe reads entry `rd_ptr` of the play bank, then `rd_ptr`++.
  - The strobe after entry BUFF_SIZE-1 was read is the bank-end strobe:
    - If the write side is FULL: `swap` pulses, `play_bank` toggles, `rd_ptr`=0, and entry 0 of the new play bank is read on that same strobe (`rd_ptr` becomes 1).
    - Otherwise go to STARVED: outputs 0 and `underrun` pulses.
  - STARVED: every strobe without FULL outputs 0 with an `underrun` pulse. A strobe with FULL performs the swap as above and returns to PLAY.
- **Swap details:** FULL is sampled as the registered state at the strobe cycle. A fill that completes on the strobe cycle itself does not swap until the next strobe.
- **Swap cycle handshake:** `wr_ready` stays 0 during the swap cycle and rises the cycle after.
- **Width rules:** outputs are zero-padded in the LSBs with no sign extension or rounding. `rd_ptr` and `wr_ptr` wrap modulo BUFF_SIZE.
- **Reset:** mid-operation reset discards both banks' contents logically. The state returns to IDLE/FILL with `play_bank`=1 (so bank 0 fills first) and `wr_ptr`=`rd_ptr`=0.

## Timing
- **Reset values:**
  - `wr_ready`=1
  - `l_dout`=`r_dout`=0
  - `play_bank`=1
  - `swap`=`underrun`=`underrun_sticky`=0
  - `prev_lrck`=0
- **Write latency:** a written entry is readable from the cycle after the write. Throughput is one entry per `clk`.
- **Output latency:** `l_dout`/`r_dout` update exactly 2 `clk` edges after the edge at which `lrck` is first sampled low: strobe edge, then RAM read edge, then output register edge. They hold until the next update.
- **Swap pulse timing:** `swap` and `underrun` assert for the single cycle after the strobe edge.
- **Bit budget:** the strobe and 2-cycle latency fit within the 32-bck half-frame; `i2s_tx` must capture words at the next LRCK edge.

## Test plan
- **Reset idle:** reset, then toggle `lrck` for 3 frames with no writes. Expect outputs 0, `underrun`=0, `wr_ready`=1, `play_bank`=1.
- **Fill and first swap:** write 64 pairs (L=n, R=-n) back-to-back. Expect `wr_ready` low after the 64th write. At the next strobe, `swap` pulses, `play_bank`=0, and after 2 edges `l_dout`=0x00000000 (n=0). Over successive frames `l_dout`={24'd n,8'h00} and `r_dout`={-n,8'h00}.
- **Continuous streaming:** keep the fill bank refilled. Expect a seamless transition at frame 64 (entry 63 of bank 0, then entry 0 of bank 1), with no underrun.
- **Starvation:** after bank 0 plays, write only 10 entries. Expect outputs 0 and an `underrun` pulse each frame, and `underrun_sticky`=1. Complete the remaining 54 writes; expect a swap at the next strobe.
- **Simultaneous completion:** complete the 64th write on the strobe cycle at bank end. Expect an underrun that frame and a swap at the following strobe.
- **Reset mid-play:** assert `rst` at rd_ptr=30. Expect all outputs to return to reset values the next cycle and `underrun_sticky` to clear.
